// File: rtl/compute_gradients_if.sv
// Bus between the gradient engine, its blurred-image BRAM and the x/y gradient BRAMs.
// master = gradient engine, slave = memories/controller side.
interface compute_gradients_if #(
  parameter int DIMENSION = 64,
  parameter int BIT_DEPTH = 8
);
  localparam int AW = $clog2(DIMENSION * DIMENSION);

  logic                        start;
  logic [AW-1:0]               img_read_addr;
  logic [BIT_DEPTH-1:0]        img_read;
  logic [AW-1:0]               grad_write_addr;
  logic signed [BIT_DEPTH-1:0] x_grad_out;
  logic signed [BIT_DEPTH-1:0] y_grad_out;
  logic                        grad_wea;
  logic                        busy;
  logic                        gradients_done;

  modport master (
    input  start, img_read,
    output img_read_addr, grad_write_addr, x_grad_out, y_grad_out,
           grad_wea, busy, gradients_done
  );

  modport slave (
    output start, img_read,
    input  img_read_addr, grad_write_addr, x_grad_out, y_grad_out,
           grad_wea, busy, gradients_done
  );
endinterface

// File: rtl/compute_gradients.sv
// Central-difference x/y gradients for one pyramid level, raster order, 7 cycles per pixel
// (6 fetch cycles against a 2-cycle-latency BRAM, 1 write cycle).
module compute_gradients #(
  parameter int DIMENSION = 64,
  parameter int BIT_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_in,
  compute_gradients_if.master  bus
);
  localparam int CW = $clog2(DIMENSION);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t                      state;
  logic [CW-1:0]               x, y;
  logic [2:0]                  c;
  logic [BIT_DEPTH-1:0]        left, right, up;

  logic [CW-1:0]               xl, xr, yu, yd, nx, ny, nxl;
  logic                        last;
  logic [2*CW-1:0]             next_addr;
  logic signed [BIT_DEPTH:0]   dx, dy;

  // Border-clamped neighbours of the current pixel and of the next raster pixel.
  always_comb begin
    xl        = (x == '0) ? '0 : x - CW'(1);
    xr        = (x == '1) ? x  : x + CW'(1);
    yu        = (y == '0) ? '0 : y - CW'(1);
    yd        = (y == '1) ? y  : y + CW'(1);
    nx        = x + CW'(1);
    ny        = (x == '1) ? y + CW'(1) : y;
    nxl       = (nx == '0) ? '0 : nx - CW'(1);
    last      = (x == '1) && (y == '1);
    case (c)
      3'd0:    next_addr = {y, xr};
      3'd1:    next_addr = {yu, x};
      default: next_addr = {yd, x};
    endcase
  end

  // The down sample is used straight off the read port in its capture cycle,
  // so both gradients are registered on the same edge that ends the fetch.
  assign dx = $signed({1'b0, right})        - $signed({1'b0, left});
  assign dy = $signed({1'b0, bus.img_read}) - $signed({1'b0, up});

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state               <= IDLE;
      x                   <= '0;
      y                   <= '0;
      c                   <= '0;
      left                <= '0;
      right               <= '0;
      up                  <= '0;
      bus.img_read_addr   <= '0;
      bus.grad_write_addr <= '0;
      bus.x_grad_out      <= '0;
      bus.y_grad_out      <= '0;
      bus.grad_wea        <= 1'b0;
      bus.busy            <= 1'b0;
      bus.gradients_done  <= 1'b0;
    end else begin
      bus.grad_wea       <= 1'b0;
      bus.gradients_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state             <= FETCH;
            x                 <= '0;
            y                 <= '0;
            c                 <= '0;
            bus.img_read_addr <= '0;
            bus.busy          <= 1'b1;
          end
        end
        FETCH: begin
          c <= c + 3'd1;
          if (c < 3'd3) bus.img_read_addr <= next_addr;
          case (c)
            3'd2: left  <= bus.img_read;
            3'd3: right <= bus.img_read;
            3'd4: up    <= bus.img_read;
            3'd5: begin
              bus.x_grad_out      <= BIT_DEPTH'(dx >>> 1);
              bus.y_grad_out      <= BIT_DEPTH'(dy >>> 1);
              bus.grad_write_addr <= {y, x};
              bus.grad_wea        <= 1'b1;
              state               <= WRITE;
            end
            default: ;
          endcase
        end
        WRITE: begin
          c <= '0;
          if (last) begin
            state              <= DONE;
            bus.gradients_done <= 1'b1;
          end else begin
            x                 <= nx;
            y                 <= ny;
            bus.img_read_addr <= {ny, nxl};
            state             <= FETCH;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/compute_gradients.md
# compute_gradients

Computes signed central-difference x/y gradients for one Gaussian-pyramid level and writes them into that level's x- and y-gradient BRAMs. It sits directly upstream of descriptor generation, whose histogram units read these BRAMs. One instance is used per level; the instance is sized by `DIMENSION` (the octave image width/height).

## Interface
- `DIMENSION`, 64, image width = height in pixels (power of two, ≥4)
- `BIT_DEPTH`, 8, pixel width (unsigned) and gradient width (signed)

- `clk` in 1: clock
- `rst_in` in 1: asynchronous, active-high reset
- `start` in 1: begin a full-image pass; sampled only in IDLE
- `img_read_addr` out `$clog2(DIMENSION*DIMENSION)`: blurred-image BRAM read address, row-major `y*DIMENSION+x`
- `img_read` in `BIT_DEPTH`: BRAM read data, unsigned, 2-cycle read latency
- `grad_write_addr` out `$clog2(DIMENSION*DIMENSION)`: shared write address for both gradient BRAMs
- `x_grad_out` out `BIT_DEPTH` signed: x gradient
- `y_grad_out` out `BIT_DEPTH` signed: y gradient
- `grad_wea` out 1: write enable for both gradient BRAMs
- `busy` out 1: high whenever state ≠ IDLE
- `gradients_done` out 1: one-cycle pulse at end of pass

## Operation
- States: IDLE → FETCH → WRITE → (FETCH of next pixel | DONE) → IDLE.
- Pixels are visited in raster order: x increments fastest; (0,0) first, (D-1,D-1) last.
- Neighbour coordinates are clamped at borders: L = max(x-1,0), R = min(x+1,D-1), U = max(y-1,0), Dn = min(y+1,D-1). Border pixels therefore use a one-sided difference against the centre pixel.
- FETCH uses a 3-bit counter c = 0..5:
  - In cycles c=0,1,2,3, `img_read_addr` presents L, R, U, Dn respectively, each on the same row/column as the centre.
  - `img_read` is captured at the end of c=2,3,4,5 into the left, right, up and down registers.
- Arithmetic:
  - dx = {1'b0,right} − {1'b0,left}, 9-bit signed; `x_grad_out` = dx >>> 1, truncated to `BIT_DEPTH`. Range −128..127; the shift rounds toward −∞.
  - dy = down − up, same rules, gives `y_grad_out`.
- WRITE is one cycle:
  - `grad_wea`=1, `grad_write_addr` = y*D+x, gradients valid.
  - If the pixel is not last: advance x (wrap to 0 and increment y at x=D-1), go to FETCH with c=0.
  - Otherwise go to DONE.
- DONE is one cycle with `gradients_done`=1, then IDLE.
- `start` while busy is ignored; there is no queuing.
- A new `start` in IDLE re-runs the full pass from (0,0).

## Timing
- Reset values (applied asynchronously): state IDLE; `img_read_addr`, `grad_write_addr`, `x_grad_out`, `y_grad_out` = 0; `grad_wea`, `busy`, `gradients_done` = 0; x, y, c = 0.
- Edge numbering: start is sampled at edge E0.
- All outputs are registered. `img_read_addr` = L of (0,0) is valid in the cycle after E0.
- Pixel period is 7 cycles: 6 FETCH + 1 WRITE.
- The first `grad_wea` is high between E6 and E7.
- With N = D²:
  - The last write is high between E(7N−1) and E7N.
  - `gradients_done` is high between E7N and E7N+1.
  - `busy` is high from E0 through the DONE cycle.
- `grad_wea` is never high for two consecutive cycles.
- `rst_in` mid-pass returns to IDLE immediately with no done pulse. Writes already committed are not undone, and the next pass restarts at (0,0).
- `img_read` is ignored outside the capture cycles.

## Test plan
- Horizontal ramp, D=8, p(x,y)=10x, start pulse:
  - Interior `x_grad_out`=10; x=0 and x=7 give 5.
  - All `y_grad_out`=0.
  - Exactly 64 writes, addresses 0..63 in order.
- Extremes:
  - Neighbours left=255/right=0 → −128 (8'h80).
  - left=0/right=255 → 127.
  - left=1/right=0 → −1.
  - up=0/down=255 on y gives `y_grad_out`=127.
- Cycle count, D=8, start at E0:
  - First `grad_wea` after E6, at address 0.
  - Last write after E447, at address 63.
  - `gradients_done` high only after E448.
  - `busy` falls at E449.
- Start ignored: pulse `start` at E100 during a pass → write sequence and done timing are identical to the first run; exactly one done pulse.
- Asynchronous reset mid-pass:
  - Assert `rst_in` between edges during pixel 20 → all outputs are 0 immediately, no done pulse.
  - A later start produces writes from address 0 with E6 latency.
- Back-to-back passes: start on the cycle after done → second pass has identical output and timing to the first.
